// File: rtl/rom_load_ctrl_if.sv
// Bus bundle for the boot-load controller: load request, byte stream,
// core fetch request, ROM port and status. The controller takes the slave
// view and the environment (SoC glue or bench) takes the master view.
interface rom_load_ctrl_if #(
   parameter int ADDR_W = 14
);

   // load request
   logic              start_i;
   logic [ADDR_W:0]   len_i;

   // firmware byte stream
   logic [7:0]        s_data_i;
   logic              s_valid_i;
   logic              s_ready_o;

   // core fetch path
   logic              core_req_i;
   logic [ADDR_W-1:0] core_addr_i;
   logic              core_gnt_o;

   // ROM port
   logic              rom_ce_o;
   logic              rom_we_o;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [31:0]       rom_wdata_o;

   // core reset and status
   logic              core_rst_no;
   logic              busy_o;
   logic              done_o;
   logic              err_o;

   modport slave (
      input  start_i, len_i, s_data_i, s_valid_i, core_req_i, core_addr_i,
      output s_ready_o, core_gnt_o, rom_ce_o, rom_we_o, rom_addr_o,
             rom_wdata_o, core_rst_no, busy_o, done_o, err_o
   );

   modport master (
      output start_i, len_i, s_data_i, s_valid_i, core_req_i, core_addr_i,
      input  s_ready_o, core_gnt_o, rom_ce_o, rom_we_o, rom_addr_o,
             rom_wdata_o, core_rst_no, busy_o, done_o, err_o
   );

endinterface

// File: rtl/rom_load_ctrl.sv
// Boot-load controller for the instruction ROM. Assembles a byte stream into
// little-endian 32-bit words, writes them through the single ROM port, keeps
// the core in reset during the load plus a fixed hold window, and hands the
// ROM port to the core fetch path only while the core is running.
module rom_load_ctrl #(
   parameter int ADDR_W   = 14,
   parameter int RST_HOLD = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   rom_load_ctrl_if.slave bus
);

   localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RST_HOLD - 1);
   localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_RUN   = 2'd1,
      S_LOAD  = 2'd2,
      S_WRITE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              loaded_q, loaded_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
   logic [1:0]        idx_q, idx_d;
   logic              crst_n_q, crst_n_d;
   logic              done_q, done_d;
   logic [31:0]       word_q;

   logic              s_ready;
   logic              accept;
   logic [ADDR_W:0]   len_clamped;
   logic [ADDR_W:0]   wr_addr_inc;
   logic              rom_ce;
   logic              rom_we;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_wdata;
   logic              core_gnt;

   // A requested length beyond the ROM depth is limited to a full-depth load.
   assign len_clamped = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
   assign wr_addr_inc = wr_addr_q + (ADDR_W+1)'(1);
   assign s_ready     = (state_q == S_LOAD);
   assign accept      = s_ready & bus.s_valid_i;

   // Next-state, datapath control and the combinational ROM-port mux.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      loaded_d  = loaded_q;
      err_d     = err_q;
      len_d     = len_q;
      wr_addr_d = wr_addr_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      rom_ce    = 1'b0;
      rom_we    = 1'b0;
      rom_addr  = '0;
      rom_wdata = '0;
      core_gnt  = 1'b0;

      // A load request while a load or hold is in progress is only flagged.
      if (bus.start_i && (state_q != S_RUN)) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_HOLD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = S_RUN;
               cnt_d    = '0;
               done_d   = loaded_q;
               loaded_d = 1'b0;
            end
         end

         S_RUN: begin
            // Zero-latency handover of the ROM port to the core.
            core_gnt = bus.core_req_i;
            rom_ce   = bus.core_req_i;
            rom_addr = bus.core_addr_i;
            if (bus.start_i) begin
               err_d     = 1'b0;
               len_d     = len_clamped;
               wr_addr_d = '0;
               idx_d     = 2'd0;
               loaded_d  = 1'b1;
               cnt_d     = '0;
               state_d   = (len_clamped == '0) ? S_HOLD : S_LOAD;
            end
         end

         S_LOAD: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            rom_ce    = 1'b1;
            rom_we    = 1'b1;
            rom_addr  = wr_addr_q[ADDR_W-1:0];
            rom_wdata = word_q;
            wr_addr_d = wr_addr_inc;
            // Compared at full width so a 2^ADDR_W-word load terminates.
            if (wr_addr_inc == len_q) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else begin
               state_d = S_LOAD;
            end
         end

         default: begin
            state_d = S_HOLD;
            cnt_d   = '0;
         end
      endcase

      // Core reset is released exactly in the cycles spent in RUN.
      crst_n_d = (state_d == S_RUN);
   end

   // Control state; async reset parks the block in HOLD with nothing loaded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_HOLD;
         cnt_q     <= '0;
         loaded_q  <= 1'b0;
         err_q     <= 1'b0;
         len_q     <= '0;
         wr_addr_q <= '0;
         idx_q     <= 2'd0;
         crst_n_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         loaded_q  <= loaded_d;
         err_q     <= err_d;
         len_q     <= len_d;
         wr_addr_q <= wr_addr_d;
         idx_q     <= idx_d;
         crst_n_q  <= crst_n_d;
         done_q    <= done_d;
      end
   end

   // Word assembly: each accepted byte lands in the lane selected by idx.
   // Unreset on purpose; a partial word is discarded via idx and state.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         word_q[8*idx_q +: 8] <= bus.s_data_i;
      end
   end

   assign bus.s_ready_o   = s_ready;
   assign bus.core_gnt_o  = core_gnt;
   assign bus.rom_ce_o    = rom_ce;
   assign bus.rom_we_o    = rom_we;
   assign bus.rom_addr_o  = rom_addr;
   assign bus.rom_wdata_o = rom_wdata;
   assign bus.core_rst_no = crst_n_q;
   assign bus.busy_o      = (state_q != S_RUN);
   assign bus.done_o      = done_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: reset release, word loads with and
// without stream stalls, core arbitration, error flag and reset mid-word.
// ROM writes are checked against a scoreboard filled when loads are issued.
module tb_rom_load_ctrl;

   localparam int ADDR_W   = 14;
   localparam int RST_HOLD = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   n_writes;
   int   n_done;
   wr_t  exp_q[$];
   logic [7:0] img [8];

   rom_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   rom_load_ctrl #(
      .ADDR_W  (ADDR_W),
      .RST_HOLD(RST_HOLD)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every ROM write, and checks that the
   // core never holds the port while the loader is busy.
   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         if (bus.rom_we_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(bus.rom_we_o), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.rom_addr_o), 32'(e.addr));
               chk("wr_data", bus.rom_wdata_o, e.data);
               n_writes++;
            end
         end
         if (bus.busy_o && bus.core_req_i) begin
            chk("gnt_when_busy", 32'(bus.core_gnt_o), 32'd0);
            chk("ce_when_busy", 32'(bus.rom_ce_o), 32'(bus.rom_we_o));
         end
         if (bus.done_o) n_done++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Release reset and check the hold window timing.
   task automatic reset_release();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= RST_HOLD; i++) begin
         step();
         chk("rel_done", 32'(bus.done_o), 32'd0);
         if (i == RST_HOLD - 1) begin
            chk("rel_rst_low", 32'(bus.core_rst_no), 32'd0);
            chk("rel_busy_hi", 32'(bus.busy_o), 32'd1);
         end
         if (i == RST_HOLD) begin
            chk("rel_rst_high", 32'(bus.core_rst_no), 32'd1);
            chk("rel_busy_lo", 32'(bus.busy_o), 32'd0);
         end
      end
   endtask

   // Present one byte after a gap and hold it until it is accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      bit   ok;
      bus.s_valid_i = 1'b0;
      repeat (gap) step();
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = b;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         r = bus.s_ready_o;
         step();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
      bus.s_valid_i = 1'b0;
   endtask

   // Issue a load of len words from img; optionally pre-fill the scoreboard,
   // stall the stream, inject a stray start, or stop after nbytes bytes.
   task automatic do_load(input int len, input bit push, input bit gaps,
                          input int err_at, input int nbytes);
      wr_t e;
      if (push) begin
         for (int w = 0; w < len; w++) begin
            e.addr = ADDR_W'(w);
            e.data = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
            exp_q.push_back(e);
         end
      end
      bus.start_i = 1'b1;
      bus.len_i   = (ADDR_W+1)'(len);
      step();
      bus.start_i = 1'b0;
      chk("start_rst_low", 32'(bus.core_rst_no), 32'd0);
      chk("start_busy", 32'(bus.busy_o), 32'd1);
      for (int k = 0; k < nbytes; k++) begin
         if (k == err_at) begin
            bus.start_i = 1'b1;
            bus.len_i   = (ADDR_W+1)'(1);
            step();
            bus.start_i = 1'b0;
            chk("err_set", 32'(bus.err_o), 32'd1);
         end
         send_byte(img[k], gaps ? (k % 4) : 0);
      end
   endtask

   // Expect n-1 more hold cycles, then RUN with a one-cycle done pulse.
   task automatic wait_run(input int n);
      repeat (n - 1) step();
      chk("hold_rst_low", 32'(bus.core_rst_no), 32'd0);
      chk("hold_no_done", 32'(bus.done_o), 32'd0);
      step();
      chk("run_rst_high", 32'(bus.core_rst_no), 32'd1);
      chk("run_done", 32'(bus.done_o), 32'd1);
      step();
      chk("done_one_cycle", 32'(bus.done_o), 32'd0);
   endtask

   initial begin
      errors = 0; checks = 0; n_writes = 0; n_done = 0;
      rst_n = 1'b0;
      bus.start_i = 1'b0; bus.len_i = '0;
      bus.s_data_i = 8'h00; bus.s_valid_i = 1'b0;
      bus.core_req_i = 1'b1; bus.core_addr_i = ADDR_W'(5);
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

      // Reset values, with a core request pending.
      repeat (3) step();
      chk("rst_core_rst", 32'(bus.core_rst_no), 32'd0);
      chk("rst_ready", 32'(bus.s_ready_o), 32'd0);
      chk("rst_ce", 32'(bus.rom_ce_o), 32'd0);
      chk("rst_we", 32'(bus.rom_we_o), 32'd0);
      chk("rst_addr", 32'(bus.rom_addr_o), 32'd0);
      chk("rst_wdata", bus.rom_wdata_o, 32'd0);
      chk("rst_gnt", 32'(bus.core_gnt_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd1);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk("rst_err", 32'(bus.err_o), 32'd0);

      // Scenario 1: reset release.
      reset_release();

      // Scenario 4: zero-latency arbitration in RUN.
      chk("arb_ce", 32'(bus.rom_ce_o), 32'd1);
      chk("arb_addr", 32'(bus.rom_addr_o), 32'd5);
      chk("arb_gnt", 32'(bus.core_gnt_o), 32'd1);
      chk("arb_we", 32'(bus.rom_we_o), 32'd0);
      bus.core_addr_i = ADDR_W'(9);
      #1;
      chk("arb_addr_follow", 32'(bus.rom_addr_o), 32'd9);
      bus.core_req_i = 1'b0;
      #1;
      chk("arb_ce_idle", 32'(bus.rom_ce_o), 32'd0);
      chk("arb_gnt_idle", 32'(bus.core_gnt_o), 32'd0);
      bus.core_req_i = 1'b1;

      // Scenario 2: two-word back-to-back load, core requesting throughout.
      do_load(2, 1'b1, 1'b0, -1, 8);
      wait_run(RST_HOLD + 1);
      chk("s2_writes", 32'(n_writes), 32'd2);

      // Scenario 3: same load with stream stalls.
      do_load(2, 1'b1, 1'b1, -1, 8);
      wait_run(RST_HOLD + 1);
      chk("s3_writes", 32'(n_writes), 32'd4);

      // Scenario 5: stray start during LOAD, then zero-length load.
      do_load(2, 1'b1, 1'b0, 5, 8);
      wait_run(RST_HOLD + 1);
      chk("s5_err_sticky", 32'(bus.err_o), 32'd1);
      chk("s5_writes", 32'(n_writes), 32'd6);
      do_load(0, 1'b0, 1'b0, -1, 0);
      chk("s5_err_clear", 32'(bus.err_o), 32'd0);
      wait_run(RST_HOLD);

      // Scenario 6: async reset after two bytes of the first word.
      do_load(2, 1'b0, 1'b0, -1, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_core", 32'(bus.core_rst_no), 32'd0);
      chk("mid_rst_we", 32'(bus.rom_we_o), 32'd0);
      chk("mid_rst_ready", 32'(bus.s_ready_o), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy_o), 32'd1);
      repeat (2) step();
      reset_release();

      // Fresh load after reset: byte lanes must start from lane 0.
      img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
      do_load(1, 1'b1, 1'b1, -1, 4);
      wait_run(RST_HOLD + 1);
      repeat (3) step();
      chk("total_writes", 32'(n_writes), 32'd7);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("done_pulses", 32'(n_done), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
